rf_param_sync: RTL and testbench

- Parametrised successor to the multicycle CPU's 32x32 register file: 2 registered read ports, 1 write port.
- Adds synchronous reset with a sweep-clear FSM, a ready flag, read enable with output hold, write-to-read bypass, and an optional hard-wired zero register.
- Sits in the decode stage of the multicycle datapath. rd1/rd2 feed the A/B latches directly.

---
 rtl/rf_param_sync.sv | 190 +++++++++++++++++++
 tb/tb_rf_param_sync.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rf_param_sync.sv
// rtl/rf_param_sync.sv - parametrised 2R1W register file with sweep-clear init, bypass and optional zero register
//
// Purpose: decode-stage register file. After reset an INIT sweep writes every
// entry (PRELOAD_IDX gets PRELOAD_VAL, the rest 0), then ready rises and the
// file runs with registered, enable-gated reads and a write-to-read bypass.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   w/wr/wd      write enable, address, data
//   re           read enable; rd1/rd2 hold while low
//   rr1/rr2      read addresses
//   rd1/rd2      registered read data
//   ready        1 once the init sweep has completed
//   iss/iss_rd   (RF_SCOREBOARD_EN only) mark a register busy
//   busy1/busy2  (RF_SCOREBOARD_EN only) registered busy bits for rr1/rr2
//
// Optional feature macro: RF_SCOREBOARD_EN (per-register busy scoreboard).

module rf_param_sync #(
    parameter int                 DATA_W      = 32,
    parameter int                 ADDR_W      = 5,
    parameter int                 R0_ZERO     = 1,
    parameter int                 PRELOAD_IDX = 2,
    parameter logic [DATA_W-1:0]  PRELOAD_VAL = DATA_W'(32'h0000_0123)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w,
    input  logic [ADDR_W-1:0] wr,
    input  logic [DATA_W-1:0] wd,
    input  logic              re,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
`ifdef RF_SCOREBOARD_EN
    input  logic              iss,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              busy1,
    output logic              busy2,
`endif
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;
    // clr_idx carries one extra bit so the increment past the last entry never wraps to 0.
    localparam logic [ADDR_W:0]   LAST_IDX     = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   IDX_ONE      = (ADDR_W+1)'(1);
    // An out-of-range preload index simply never matches during the sweep.
    localparam bit                PRELOAD_EN   = (PRELOAD_IDX >= 0) && (PRELOAD_IDX < DEPTH);
    localparam logic [ADDR_W-1:0] PRELOAD_ADDR = ADDR_W'(PRELOAD_IDX);
    localparam bit                ZERO_EN      = (R0_ZERO != 0);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q,   state_d;
    logic [ADDR_W:0]   clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] rd1_q,     rd1_d;
    logic [DATA_W-1:0] rd2_q,     rd2_d;
    logic              ready_q,   ready_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              wr_ok;

`ifdef RF_SCOREBOARD_EN
    logic [DEPTH-1:0]  busy_q,  busy_d;
    logic              busy1_q, busy1_d;
    logic              busy2_q, busy2_d;
`endif

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        ready_d   = ready_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        // A RUN write to register 0 is discarded when it is hard-wired to zero.
        wr_ok     = (state_q == ST_RUN) && w && !(ZERO_EN && (wr == '0));
`ifdef RF_SCOREBOARD_EN
        busy_d    = busy_q;
        busy1_d   = busy1_q;
        busy2_d   = busy2_q;
`endif

        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q[ADDR_W-1:0];
            mem_wdata = (PRELOAD_EN && (mem_waddr == PRELOAD_ADDR)) ? PRELOAD_VAL : '0;
            clr_idx_d = clr_idx_q + IDX_ONE;
            rd1_d     = '0;
            rd2_d     = '0;
            if (clr_idx_q == LAST_IDX) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
`ifdef RF_SCOREBOARD_EN
            busy_d  = '0;
            busy1_d = 1'b0;
            busy2_d = 1'b0;
`endif
        end else begin
            mem_we    = wr_ok;
            mem_waddr = wr;
            mem_wdata = wd;

            if (re) begin
                // Per port: zero register, then same-edge write bypass, then array.
                if (ZERO_EN && (rr1 == '0))      rd1_d = '0;
                else if (wr_ok && (wr == rr1))   rd1_d = wd;
                else                             rd1_d = mem[rr1];

                if (ZERO_EN && (rr2 == '0))      rd2_d = '0;
                else if (wr_ok && (wr == rr2))   rd2_d = wd;
                else                             rd2_d = mem[rr2];
`ifdef RF_SCOREBOARD_EN
                if (ZERO_EN && (rr1 == '0))      busy1_d = 1'b0;
                else if (wr_ok && (wr == rr1))   busy1_d = 1'b0;
                else                             busy1_d = busy_q[rr1];

                if (ZERO_EN && (rr2 == '0))      busy2_d = 1'b0;
                else if (wr_ok && (wr == rr2))   busy2_d = 1'b0;
                else                             busy2_d = busy_q[rr2];
`endif
            end

`ifdef RF_SCOREBOARD_EN
            // Clear first, then set, so a same-index issue on the write edge wins.
            if (wr_ok) begin
                busy_d[wr] = 1'b0;
            end
            if (iss && !(ZERO_EN && (iss_rd == '0))) begin
                busy_d[iss_rd] = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            ready_q   <= 1'b0;
`ifdef RF_SCOREBOARD_EN
            busy_q    <= '0;
            busy1_q   <= 1'b0;
            busy2_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            ready_q   <= ready_d;
`ifdef RF_SCOREBOARD_EN
            busy_q    <= busy_d;
            busy1_q   <= busy1_d;
            busy2_q   <= busy2_d;
`endif
        end
    end

    // Array has no reset: the reset edge leaves contents alone and the sweep rewrites them.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd1   = rd1_q;
    assign rd2   = rd2_q;
    assign ready = ready_q;
`ifdef RF_SCOREBOARD_EN
    assign busy1 = busy1_q;
    assign busy2 = busy2_q;
`endif

endmodule

// File: tb/tb_rf_param_sync.sv
// tb/tb_rf_param_sync.sv - scoreboard bench for rf_param_sync (zero-reg and ordinary-reg0 builds)

module tb_rf_param_sync;

    logic        clk = 1'b0;
    logic        rst, w, re;
    logic [4:0]  wr, rr1, rr2;
    logic [31:0] wd;
    logic [31:0] rd1, rd2, nz_rd1, nz_rd2;
    logic        ready, nz_ready;
`ifdef RF_SCOREBOARD_EN
    logic        iss;
    logic [4:0]  iss_rd;
    logic        busy1, busy2, nz_busy1, nz_busy2;
`endif

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        int          due;
        logic [31:0] rd1, rd2, nz1, nz2;
        logic        rdy;
        logic        b1, b2;
    } exp_t;

    exp_t sb[$];

    rf_param_sync u_dut (
        .clk(clk), .rst(rst), .w(w), .wr(wr), .wd(wd), .re(re), .rr1(rr1), .rr2(rr2),
        .rd1(rd1), .rd2(rd2),
`ifdef RF_SCOREBOARD_EN
        .iss(iss), .iss_rd(iss_rd), .busy1(busy1), .busy2(busy2),
`endif
        .ready(ready)
    );

    rf_param_sync #(.R0_ZERO(0)) u_nz (
        .clk(clk), .rst(rst), .w(w), .wr(wr), .wd(wd), .re(re), .rr1(rr1), .rr2(rr2),
        .rd1(nz_rd1), .rd2(nz_rd2),
`ifdef RF_SCOREBOARD_EN
        .iss(iss), .iss_rd(iss_rd), .busy1(nz_busy1), .busy2(nz_busy2),
`endif
        .ready(nz_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string nm, input int d, input logic [31:0] e1, e2, n1, n2,
                        input logic erdy, eb1, eb2);
        exp_t e;
        e.name = nm; e.due = d;
        e.rd1 = e1; e.rd2 = e2; e.nz1 = n1; e.nz2 = n2;
        e.rdy = erdy; e.b1 = eb1; e.b2 = eb2;
        sb.push_back(e);
    endtask

    // Apply one cycle of inputs and queue what both instances must show after the next edge.
    task automatic drive(input logic i_rst, i_w, input logic [4:0] i_wr, input logic [31:0] i_wd,
                         input logic i_re, input logic [4:0] i_rr1, i_rr2,
                         input logic i_iss, input logic [4:0] i_iss_rd,
                         input string nm, input logic [31:0] e1, e2, n1, n2,
                         input logic erdy, eb1, eb2);
        rst = i_rst; w = i_w; wr = i_wr; wd = i_wd; re = i_re; rr1 = i_rr1; rr2 = i_rr2;
`ifdef RF_SCOREBOARD_EN
        iss = i_iss; iss_rd = i_iss_rd;
`else
        if (i_iss) $display("note: iss ignored, i_iss_rd=%0d", i_iss_rd);
`endif
        push(nm, cyc + 1, e1, e2, n1, n2, erdy, eb1, eb2);
        @(negedge clk);
    endtask

    // Hold rst low with write/read traffic that INIT must ignore; ready only after edge n when fin.
    task automatic sweep(input string nm, input int n, input bit fin);
        rst = 1'b0; w = 1'b1; wr = 5'd5; wd = 32'h0000_FFFF; re = 1'b1; rr1 = 5'd5; rr2 = 5'd2;
`ifdef RF_SCOREBOARD_EN
        iss = 1'b1; iss_rd = 5'd6;
`endif
        for (int k = 1; k <= n; k++)
            push(nm, cyc + k, 32'h0, 32'h0, 32'h0, 32'h0, (fin && k == n), 1'b0, 1'b0);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] init_val(input int i);
        return (i == 2) ? 32'h0000_0123 : 32'h0;
    endfunction

    // Monitor: outputs change only on posedge, so compare at each negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (e.due < cyc) begin
                    n_fail++;
                    $display("FAIL %s: check missed, now cycle %0d, due %0d", e.name, cyc, e.due);
                end else if (rd1 !== e.rd1 || rd2 !== e.rd2 || ready !== e.rdy ||
                             nz_rd1 !== e.nz1 || nz_rd2 !== e.nz2 || nz_ready !== e.rdy) begin
                    n_fail++;
                    $display("FAIL %s: got rd1=%h rd2=%h ready=%b nz_rd1=%h nz_rd2=%h nz_ready=%b, want rd1=%h rd2=%h ready=%b nz_rd1=%h nz_rd2=%h",
                             e.name, rd1, rd2, ready, nz_rd1, nz_rd2, nz_ready,
                             e.rd1, e.rd2, e.rdy, e.nz1, e.nz2);
                end
`ifdef RF_SCOREBOARD_EN
                else if (busy1 !== e.b1 || busy2 !== e.b2) begin
                    n_fail++;
                    $display("FAIL %s: got busy1=%b busy2=%b, want busy1=%b busy2=%b",
                             e.name, busy1, busy2, e.b1, e.b2);
                end
`endif
            end
        end
    end

    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset", 0, 0, 0, 0, 0, 0, 0);
        sweep("init_sweep", 32, 1);

        for (int i = 0; i < 32; i += 2)
            drive(0, 0, 0, 0, 1, 5'(i), 5'(i + 1), 0, 0, $sformatf("readback_%0d", i),
                  init_val(i), init_val(i + 1), init_val(i), init_val(i + 1), 1, 0, 0);

        drive(0, 1, 7, 32'hDEADBEEF, 0, 7, 8, 0, 0, "wr7_hold", 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 7, 8, 0, 0, "rd7", 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 1, 0, 0);
        drive(0, 1, 9, 32'h55AA, 1, 9, 9, 0, 0, "bypass9", 32'h55AA, 32'h55AA, 32'h55AA, 32'h55AA, 1, 0, 0);
        drive(0, 1, 0, 32'h1234, 1, 0, 9, 0, 0, "r0_bypass", 0, 32'h55AA, 32'h1234, 32'h55AA, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 7, 0, 0, "r0_read", 0, 32'hDEADBEEF, 32'h1234, 32'hDEADBEEF, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 7, 2, 0, 0, "hold_a", 32'hDEADBEEF, 32'h123, 32'hDEADBEEF, 32'h123, 1, 0, 0);
        drive(0, 1, 7, 32'h1, 0, 9, 9, 0, 0, "hold_b", 32'hDEADBEEF, 32'h123, 32'hDEADBEEF, 32'h123, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 9, 9, 0, 0, "hold_c", 32'hDEADBEEF, 32'h123, 32'hDEADBEEF, 32'h123, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 7, 0, 0, 0, "hold_d", 32'h1, 0, 32'h1, 32'h1234, 1, 0, 0);

`ifdef RF_SCOREBOARD_EN
        drive(0, 0, 0, 0, 0, 4, 5, 1, 4, "iss4", 32'h1, 0, 32'h1, 32'h1234, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 4, 5, 0, 0, "busy4_set", 0, 0, 0, 0, 1, 1, 0);
        drive(0, 1, 4, 32'hCAFE, 1, 4, 4, 0, 0, "busy4_clr", 32'hCAFE, 32'hCAFE, 32'hCAFE, 32'hCAFE, 1, 0, 0);
`endif

        drive(1, 1, 7, 32'hFFFF, 1, 7, 2, 0, 0, "mid_rst", 0, 0, 0, 0, 0, 0, 0);
        sweep("part_init", 10, 0);
        drive(1, 1, 7, 32'hFFFF, 1, 7, 2, 0, 0, "re_rst", 0, 0, 0, 0, 0, 0, 0);
        sweep("full_init", 32, 1);
        drive(0, 0, 0, 0, 1, 7, 2, 0, 0, "post_rd7", 0, 32'h123, 0, 32'h123, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 9, 0, 0, 0, "post_rd9", 0, 0, 0, 0, 1, 0, 0);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d checks never compared, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
